// File: rtl/method_test_runner.sv
// -----------------------------------------------------------------------------
// method_test_runner
//
// Purpose: sequences one test of a method on an attached DUT. After start it
// waits a startup delay and loads the DUT int/long fields for one cycle. It
// then raises method_req until the DUT reports busy and waits for busy to fall.
// The method result and int field are captured at that point and turned into
// a pass verdict. A cycle counter measures the method latency, and a timeout
// aborts a DUT that never finishes.
//
// Ports:
//   clk            clock, all state on rising edge
//   reset          synchronous active-low reset
//   start          run request (honoured in IDLE/DONE only)
//   init_ic        int field load value
//   init_lc        long field load value
//   expect_ic      expected int field after the method
//   check_ic_en    also require ic_out == expect_ic for pass
//   ic_in/ic_we    int field write data / enable   (to DUT)
//   lc_in/lc_we    long field write data / enable  (to DUT)
//   method_req     method request                  (to DUT)
//   method_busy    method executing                (from DUT)
//   method_return  method boolean result           (from DUT)
//   ic_out         int field readback              (from DUT)
//   done           run finished, held until next start/reset
//   pass           verdict, valid with done
//   timed_out      run aborted by timeout, valid with done
//   cycles         REQ+RUN cycle count, saturating
//   ret_cap        captured method_return
//   ic_cap         captured ic_out
// -----------------------------------------------------------------------------
module method_test_runner #(
  parameter int unsigned STARTUP_DELAY = 5,
  parameter int unsigned TIMEOUT       = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] init_ic,
  input  logic [63:0] init_lc,
  input  logic [31:0] expect_ic,
  input  logic        check_ic_en,
  output logic [31:0] ic_in,
  output logic        ic_we,
  output logic [63:0] lc_in,
  output logic        lc_we,
  output logic        method_req,
  input  logic        method_busy,
  input  logic        method_return,
  input  logic [31:0] ic_out,
  output logic        done,
  output logic        pass,
  output logic        timed_out,
  output logic [31:0] cycles,
  output logic        ret_cap,
  output logic [31:0] ic_cap
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DELAY,
    S_LOAD,
    S_REQ,
    S_RUN,
    S_CHECK,
    S_DONE
  } state_t;

  // 33-bit thresholds so that "count + 1 >= limit" never wraps, and a limit of
  // zero behaves like a limit of one.
  localparam logic [32:0] LP_DELAY   = 33'(STARTUP_DELAY);
  localparam logic [32:0] LP_TIMEOUT = 33'(TIMEOUT);

  state_t      r_state;
  state_t      w_state_next;

  logic [31:0] r_delay_cnt;
  logic [31:0] r_to_cnt;
  logic [31:0] r_cycles;
  logic        r_done;
  logic        r_pass;
  logic        r_timed_out;
  logic        r_ret_cap;
  logic [31:0] r_ic_cap;

  logic        w_delay_end;
  logic        w_to_hit;
  logic        w_active;
  logic        w_verdict;

  // Last DELAY cycle: the current cycle is number delay_cnt+1.
  assign w_delay_end = ({1'b0, r_delay_cnt} + 33'd1) >= LP_DELAY;
  // Timeout fires on the edge that would bring the counter to TIMEOUT.
  assign w_to_hit    = ({1'b0, r_to_cnt} + 33'd1) >= LP_TIMEOUT;
  assign w_active    = (r_state == S_REQ) || (r_state == S_RUN);
  assign w_verdict   = r_ret_cap & (~check_ic_en | (r_ic_cap == expect_ic));

  // DUT-facing strobes are pure state decodes, so a reset or timeout drops
  // them in the very next cycle.
  assign ic_we      = (r_state == S_LOAD);
  assign lc_we      = (r_state == S_LOAD);
  assign ic_in      = ic_we ? init_ic : 32'd0;
  assign lc_in      = lc_we ? init_lc : 64'd0;
  assign method_req = (r_state == S_REQ);

  assign done      = r_done;
  assign pass      = r_pass;
  assign timed_out = r_timed_out;
  assign cycles    = r_cycles;
  assign ret_cap   = r_ret_cap;
  assign ic_cap    = r_ic_cap;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic. The timeout is tested before busy so that a busy fall
  // coinciding with the timeout still ends as a timeout.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start)        w_state_next = S_DELAY;
      S_DELAY:        if (w_delay_end)  w_state_next = S_LOAD;
      S_LOAD:                           w_state_next = S_REQ;
      S_REQ: begin
        if (w_to_hit)                   w_state_next = S_DONE;
        else if (method_busy)           w_state_next = S_RUN;
      end
      S_RUN: begin
        if (w_to_hit)                   w_state_next = S_DONE;
        else if (!method_busy)          w_state_next = S_CHECK;
      end
      S_CHECK:                          w_state_next = S_DONE;
      default:                          w_state_next = S_IDLE;
    endcase
  end

  // Counters, captures and result flags
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_delay_cnt <= 32'd0;
      r_to_cnt    <= 32'd0;
      r_cycles    <= 32'd0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_timed_out <= 1'b0;
      r_ret_cap   <= 1'b0;
      r_ic_cap    <= 32'd0;
    end else begin
      if (w_active) begin
        if (r_cycles != 32'hFFFF_FFFF) begin
          r_cycles <= r_cycles + 32'd1;
        end
      end

      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_timed_out <= 1'b0;
            r_cycles    <= 32'd0;
            r_delay_cnt <= 32'd0;
            r_to_cnt    <= 32'd0;
          end
        end
        S_DELAY: begin
          if (!w_delay_end) begin
            r_delay_cnt <= r_delay_cnt + 32'd1;
          end
        end
        S_REQ, S_RUN: begin
          if (w_to_hit) begin
            r_timed_out <= 1'b1;
            r_pass      <= 1'b0;
            r_done      <= 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt + 32'd1;
            if ((r_state == S_RUN) && !method_busy) begin
              r_ret_cap <= method_return;
              r_ic_cap  <= ic_out;
            end
          end
        end
        S_CHECK: begin
          r_pass <= w_verdict;
          r_done <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_method_test_runner.sv
module tb_method_test_runner;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] init_ic;
  logic [63:0] init_lc;
  logic [31:0] expect_ic;
  logic        check_ic_en;
  logic [31:0] ic_in;
  logic        ic_we;
  logic [63:0] lc_in;
  logic        lc_we;
  logic        method_req;
  logic        method_busy;
  logic        method_return;
  logic [31:0] ic_out;
  logic        done;
  logic        pass;
  logic        timed_out;
  logic [31:0] cycles;
  logic        ret_cap;
  logic [31:0] ic_cap;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  method_test_runner #(
    .STARTUP_DELAY(5),
    .TIMEOUT(20)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .init_ic(init_ic),
    .init_lc(init_lc),
    .expect_ic(expect_ic),
    .check_ic_en(check_ic_en),
    .ic_in(ic_in),
    .ic_we(ic_we),
    .lc_in(lc_in),
    .lc_we(lc_we),
    .method_req(method_req),
    .method_busy(method_busy),
    .method_return(method_return),
    .ic_out(ic_out),
    .done(done),
    .pass(pass),
    .timed_out(timed_out),
    .cycles(cycles),
    .ret_cap(ret_cap),
    .ic_cap(ic_cap)
  );

  // DUT method model: busy rises one cycle after the first req cycle and
  // stays high for 10 cycles; busy_en=0 models a DUT that never responds.
  logic busy_en = 1'b1;
  logic m_armed = 1'b0;
  int   m_left  = 0;

  always @(posedge clk) begin
    if (method_req && !m_armed) begin
      m_armed <= 1'b1;
      if (busy_en) m_left <= 10;
    end else begin
      if (!method_req) m_armed <= 1'b0;
      if (m_left != 0) m_left <= m_left - 1;
    end
  end
  assign method_busy = (m_left != 0);

  typedef struct {
    logic        pass;
    logic        tmo;
    logic        ret;
    logic [31:0] ic;
    logic        cap_chk;
    logic [31:0] cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e_cur;
  int   we_cnt = 0;
  logic done_q = 1'b0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  always @(posedge clk) begin
    if (!reset) we_cnt = 0;
  end

  // Monitor: load pulse contents, and scoreboard pop on each completed run.
  always @(negedge clk) begin
    if (reset && (ic_we || lc_we)) begin
      check("load_we_pair", {ic_we, lc_we}, 2'b11);
      check("load_ic_in", ic_in, init_ic);
      check("load_lc_in", lc_in, init_lc);
      we_cnt++;
    end
    if (done && !done_q) begin
      n_checks++;
      assert (sb.size() != 0) else begin
        n_errors++;
        $error("FAIL sb_empty: observed done=1 expected no completion");
      end
      if (sb.size() != 0) begin
        e_cur = sb.pop_front();
        $display("run done: pass=%0d timed_out=%0d cycles=%0d ret_cap=%0d ic_cap=%0d",
                 pass, timed_out, cycles, ret_cap, ic_cap);
        check("pass", pass, e_cur.pass);
        check("timed_out", timed_out, e_cur.tmo);
        check("cycles", cycles, e_cur.cyc);
        check("req_low_at_done", method_req, 1'b0);
        check("load_pulses", we_cnt, 1);
        if (e_cur.cap_chk) begin
          check("ret_cap", ret_cap, e_cur.ret);
          check("ic_cap", ic_cap, e_cur.ic);
        end
      end
      we_cnt = 0;
    end
    done_q = done;
  end

  task automatic wait_done(input string tag);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < 300);
    n_checks++;
    assert (done === 1'b1) else begin
      n_errors++;
      $error("FAIL %s: observed done=%0b expected 1 within 300 cycles", tag, done);
    end
  endtask

  task automatic wait_req(input logic level, input string tag);
    int k = 0;
    while (method_req !== level && k < 100) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    assert (method_req === level) else begin
      n_errors++;
      $error("FAIL %s: observed method_req=%0b expected %0b", tag, method_req, level);
    end
  endtask

  task automatic run(input string tag, input logic ret, input logic [31:0] icv,
                     input logic en, input logic ben, input exp_t e);
    method_return = ret;
    ic_out        = icv;
    check_ic_en   = en;
    busy_en       = ben;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(tag);
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [255:0] all_outs();
    return {done, pass, timed_out, cycles, ret_cap, ic_cap,
            ic_we, lc_we, method_req, ic_in, lc_in};
  endfunction

  initial begin
    reset         = 1'b0;
    start         = 1'b0;
    init_ic       = 32'd7;
    init_lc       = 64'h0123_4567_89AB_CDEF;
    expect_ic     = 32'd42;
    check_ic_en   = 1'b1;
    method_return = 1'b1;
    ic_out        = 32'd42;

    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), '0);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_after_reset", {done, method_req, ic_we, cycles}, '0);

    // Nominal pass, return=0, int mismatch with/without check, timeout
    run("nominal", 1'b1, 32'd42, 1'b1, 1'b1, '{1'b1, 1'b0, 1'b1, 32'd42, 1'b1, 32'd12});
    run("ret_zero", 1'b0, 32'd42, 1'b1, 1'b1, '{1'b0, 1'b0, 1'b0, 32'd42, 1'b1, 32'd12});
    run("ic_mismatch_chk", 1'b1, 32'd41, 1'b1, 1'b1, '{1'b0, 1'b0, 1'b1, 32'd41, 1'b1, 32'd12});
    run("ic_mismatch_nochk", 1'b1, 32'd41, 1'b0, 1'b1, '{1'b1, 1'b0, 1'b1, 32'd41, 1'b1, 32'd12});
    run("timeout", 1'b1, 32'd42, 1'b1, 1'b0, '{1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd20});
    check("req_low_after_timeout", method_req, 1'b0);

    // Abort mid-RUN with a one-cycle reset
    method_return = 1'b1;
    ic_out        = 32'd42;
    check_ic_en   = 1'b1;
    busy_en       = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_req(1'b1, "abort_req_rise");
    wait_req(1'b0, "abort_req_fall");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_mid_run", all_outs(), '0);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    check("idle_after_abort", {done, method_req, ic_we, cycles}, '0);
    $display("abort: outputs cleared, idle held");

    run("after_abort", 1'b1, 32'd42, 1'b1, 1'b1, '{1'b1, 1'b0, 1'b1, 32'd42, 1'b1, 32'd12});

    // start held high: one complete run, then a restart from DONE
    sb.push_back('{1'b1, 1'b0, 1'b1, 32'd42, 1'b1, 32'd12});
    sb.push_back('{1'b1, 1'b0, 1'b1, 32'd42, 1'b1, 32'd12});
    @(negedge clk);
    start = 1'b1;
    wait_done("held_first");
    @(negedge clk);
    check("restart_from_done", done, 1'b0);
    start = 1'b0;
    wait_done("held_second");
    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
